// File: rtl/alu_bist_sequencer.sv
// Purpose: built-in self-test driver for riscv_alu; steps through a fixed vector table and scores results.
// Latency: (2 + SETTLE_CYCLES) cycles per vector; done rises NUM_VEC*(2+SETTLE_CYCLES) cycles after busy.
// Backpressure: none; start is ignored while busy and only accepted in IDLE or DONE.
module alu_bist_sequencer #(
  parameter int NUM_VEC       = 12,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        fault_inj,
  input  logic [31:0] result,
  output logic [3:0]  alu_fun,
  output logic [31:0] srcA,
  output logic [31:0] srcB,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [3:0]  fail_count,
  output logic [3:0]  first_fail_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [3:0]  fun;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  localparam logic [3:0] LAST_IDX    = 4'(NUM_VEC - 1);
  localparam logic [3:0] SETTLE_LOAD = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] NO_FAIL     = 4'hF;

  // Fixed stimulus table; shift vectors rely on the ALU using srcB[4:0] only.
  function automatic vec_t vec_entry(input logic [3:0] idx);
    vec_t v;
    case (idx)
      4'd0:    v = '{fun: 4'd0,  a: 32'd25,         b: 32'd26,         exp: 32'h0000_0033};
      4'd1:    v = '{fun: 4'd8,  a: 32'd25,         b: 32'd26,         exp: 32'hFFFF_FFFF};
      4'd2:    v = '{fun: 4'd8,  a: 32'hFFFF_FFFF,  b: 32'd1,          exp: 32'hFFFF_FFFE};
      4'd3:    v = '{fun: 4'd6,  a: 32'h0000_AAAA,  b: 32'h0000_5555,  exp: 32'h0000_FFFF};
      4'd4:    v = '{fun: 4'd7,  a: 32'h0000_AAAA,  b: 32'h0000_5555,  exp: 32'h0000_0000};
      4'd5:    v = '{fun: 4'd4,  a: 32'h0000_AAAA,  b: 32'h0000_5555,  exp: 32'h0000_FFFF};
      4'd6:    v = '{fun: 4'd5,  a: 32'h0000_FF00,  b: 32'h0000_0085,  exp: 32'h0000_07F8};
      4'd7:    v = '{fun: 4'd1,  a: 32'h0000_FF00,  b: 32'h0000_0085,  exp: 32'h001F_E000};
      4'd8:    v = '{fun: 4'd13, a: 32'h8000_FF00,  b: 32'h0000_0085,  exp: 32'hFC00_07F8};
      4'd9:    v = '{fun: 4'd2,  a: 32'h8000_FF00,  b: 32'd5,          exp: 32'h0000_0001};
      4'd10:   v = '{fun: 4'd3,  a: 32'h8000_FF00,  b: 32'd5,          exp: 32'h0000_0000};
      4'd11:   v = '{fun: 4'd9,  a: 32'h0000_FF00,  b: 32'h0000_0FFF,  exp: 32'h0000_FF00};
      default: v = '0;
    endcase
    return v;
  endfunction

  state_t     state;
  state_t     state_nxt;
  logic [3:0] vec_idx;
  logic [3:0] settle_cnt;

  vec_t       cur_vec;
  logic       mismatch;
  logic       last_vec;
  logic [3:0] fail_count_nxt;

  assign cur_vec = vec_entry(vec_idx);

  // Score the current ALU result; the fault bit flips result[0] to prove the compare path can fail.
  always_comb begin
    mismatch       = (result ^ {31'b0, fault_inj}) != cur_vec.exp;
    last_vec       = (vec_idx == LAST_IDX);
    fail_count_nxt = fail_count;
    if (mismatch && (fail_count != 4'hF)) begin
      fail_count_nxt = fail_count + 4'd1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: one DRIVE, optional SETTLE window, one CHECK per vector.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_DRIVE;
      S_DRIVE:  state_nxt = (SETTLE_CYCLES == 0) ? S_CHECK : S_SETTLE;
      S_SETTLE: if (settle_cnt == 4'd0) state_nxt = S_CHECK;
      S_CHECK:  state_nxt = last_vec ? S_DONE : S_DRIVE;
      S_DONE:   if (start) state_nxt = S_DRIVE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Operand drive, settle timing, result scoring and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_fun        <= 4'd0;
      srcA           <= 32'd0;
      srcB           <= 32'd0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      fail_count     <= 4'd0;
      first_fail_idx <= NO_FAIL;
      vec_idx        <= 4'd0;
      settle_cnt     <= 4'd0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            fail_count     <= 4'd0;
            first_fail_idx <= NO_FAIL;
            pass           <= 1'b0;
            vec_idx        <= 4'd0;
            busy           <= 1'b1;
            done           <= 1'b0;
          end
        end
        S_DRIVE: begin
          alu_fun    <= cur_vec.fun;
          srcA       <= cur_vec.a;
          srcB       <= cur_vec.b;
          settle_cnt <= SETTLE_LOAD;
        end
        S_SETTLE: begin
          if (settle_cnt != 4'd0) begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        S_CHECK: begin
          fail_count <= fail_count_nxt;
          if (mismatch && (first_fail_idx == NO_FAIL)) begin
            first_fail_idx <= vec_idx;
          end
          if (last_vec) begin
            busy <= 1'b0;
            done <= 1'b1;
            pass <= (fail_count_nxt == 4'd0);
          end else begin
            vec_idx <= vec_idx + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_bist_sequencer.sv
// Purpose: self-checking bench for alu_bist_sequencer with a behavioural riscv_alu model.
// Latency: model tracks the per-vector cycle timeline and is compared every cycle.
// Backpressure: none; start is driven directly, including while busy.
module tb_alu_bist_sequencer;

  localparam int N = 12;
  localparam int P = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        fault_inj = 1'b0;
  logic        sra_bug = 1'b0;
  logic [31:0] result;
  logic [3:0]  alu_fun;
  logic [31:0] srcA, srcB;
  logic        busy, done, pass;
  logic [3:0]  fail_count, first_fail_idx;

  logic        start2 = 1'b0;
  logic        fault2 = 1'b0;
  logic [31:0] result2;
  logic [3:0]  fun2;
  logic [31:0] a2, b2;
  logic        busy2, done2, pass2;
  logic [3:0]  fc2, ff2;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Behavioural riscv_alu; bug=1 makes SRA behave as a logical shift.
  function automatic logic [31:0] alu(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                                      input logic bug);
    logic [31:0] r;
    r = 32'd0;
    case (f)
      4'd0:  r = a + b;
      4'd1:  r = a << b[4:0];
      4'd2:  r = {31'b0, ($signed(a) < $signed(b))};
      4'd3:  r = {31'b0, (a < b)};
      4'd4:  r = a ^ b;
      4'd5:  r = a >> b[4:0];
      4'd6:  r = a | b;
      4'd7:  r = a & b;
      4'd8:  r = a - b;
      4'd9:  r = a;
      4'd13: begin
        if (bug) r = a >> b[4:0];
        else     r = $signed(a) >>> b[4:0];
      end
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  assign result  = alu(alu_fun, srcA, srcB, sra_bug);
  assign result2 = alu(fun2, a2, b2, 1'b0);

  alu_bist_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .fault_inj(fault_inj), .result(result),
    .alu_fun(alu_fun), .srcA(srcA), .srcB(srcB), .busy(busy), .done(done), .pass(pass),
    .fail_count(fail_count), .first_fail_idx(first_fail_idx)
  );

  alu_bist_sequencer #(.NUM_VEC(3), .SETTLE_CYCLES(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .fault_inj(fault2), .result(result2),
    .alu_fun(fun2), .srcA(a2), .srcB(b2), .busy(busy2), .done(done2), .pass(pass2),
    .fail_count(fc2), .first_fail_idx(ff2)
  );

  // Vector table {fun, srcA, srcB, expected}.
  logic [99:0] tbl [12] = '{
    {4'd0,  32'd25,        32'd26,        32'h0000_0033},
    {4'd8,  32'd25,        32'd26,        32'hFFFF_FFFF},
    {4'd8,  32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFE},
    {4'd6,  32'h0000_AAAA, 32'h0000_5555, 32'h0000_FFFF},
    {4'd7,  32'h0000_AAAA, 32'h0000_5555, 32'h0000_0000},
    {4'd4,  32'h0000_AAAA, 32'h0000_5555, 32'h0000_FFFF},
    {4'd5,  32'h0000_FF00, 32'h0000_0085, 32'h0000_07F8},
    {4'd1,  32'h0000_FF00, 32'h0000_0085, 32'h001F_E000},
    {4'd13, 32'h8000_FF00, 32'h0000_0085, 32'hFC00_07F8},
    {4'd2,  32'h8000_FF00, 32'd5,         32'h0000_0001},
    {4'd3,  32'h8000_FF00, 32'd5,         32'h0000_0000},
    {4'd9,  32'h0000_FF00, 32'h0000_0FFF, 32'h0000_FF00}
  };

  logic [3:0] exp_fun [12] = '{4'd0, 4'd8, 4'd8, 4'd6, 4'd7, 4'd4, 4'd5, 4'd1, 4'd13, 4'd2, 4'd3, 4'd9};

  // Model state: m_c counts clock edges since busy rose.
  logic        m_busy = 1'b0, m_done = 1'b0, m_pass = 1'b0;
  int          m_c = 0;
  logic [3:0]  m_fun = 4'd0, m_fc = 4'd0, m_ff = 4'hF;
  logic [31:0] m_a = 32'd0, m_b = 32'd0;

  // Timeline model: vector k's operands appear k*P+1 edges after busy rises, its score at (k+1)*P.
  always @(posedge clk or negedge rst_n) begin
    int k;
    if (!rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_pass = 1'b0; m_c = 0;
      m_fun = 4'd0; m_a = 32'd0; m_b = 32'd0; m_fc = 4'd0; m_ff = 4'hF;
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1'b1; m_done = 1'b0; m_pass = 1'b0; m_c = 0; m_fc = 4'd0; m_ff = 4'hF;
      end
    end else begin
      m_c = m_c + 1;
      if (m_c % P == 1) begin
        k = m_c / P;
        m_fun = tbl[k][99:96]; m_a = tbl[k][95:64]; m_b = tbl[k][63:32];
      end
      if (m_c % P == 0) begin
        k = m_c / P - 1;
        if ((alu(tbl[k][99:96], tbl[k][95:64], tbl[k][63:32], sra_bug) ^ {31'b0, fault_inj}) !== tbl[k][31:0]) begin
          if (m_fc != 4'hF) m_fc = m_fc + 4'd1;
          if (m_ff == 4'hF) m_ff = 4'(k);
        end
        if (k == N - 1) begin
          m_busy = 1'b0; m_done = 1'b1; m_pass = (m_fc == 4'd0);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("cyc_busy", busy, m_busy);
    chk("cyc_done", done, m_done);
    chk("cyc_pass", pass, m_pass);
    chk("cyc_fail_count", fail_count, m_fc);
    chk("cyc_first_fail", first_fail_idx, m_ff);
    chk("cyc_alu_fun", alu_fun, m_fun);
    chk("cyc_srcA", srcA, m_a);
    chk("cyc_srcB", srcB, m_b);
  end

  // Record the opcode of each new operand set and count busy cycles.
  logic [3:0]  seq [$];
  logic [67:0] last_ops = '0;
  int          busy_cnt = 0;
  always @(negedge clk) begin
    if (busy && ({alu_fun, srcA, srcB} != last_ops)) seq.push_back(alu_fun);
    last_ops = {alu_fun, srcA, srcB};
    if (busy) busy_cnt++;
  end

  task automatic wait_done();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    #1;
    chk("wait_done", seen, 1'b1);
  endtask

  task automatic run_and_wait();
    @(posedge clk); #1;
    start = 1'b1; busy_cnt = 0; seq.delete();
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic seen;
    // Reset values.
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_pass", pass, 1'b0);
    chk("rst_fail_count", fail_count, 4'd0);
    chk("rst_first_fail", first_fail_idx, 4'hF);
    chk("rst_alu_fun", alu_fun, 4'd0);
    chk("rst_srcA", srcA, 32'd0);
    chk("rst_srcB", srcB, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Clean pass at defaults.
    run_and_wait();
    chk("t1_busy_cycles", busy_cnt, 36);
    chk("t1_pass", pass, 1'b1);
    chk("t1_fail_count", fail_count, 4'd0);
    chk("t1_first_fail", first_fail_idx, 4'hF);
    chk("t1_seq_len", seq.size(), 12);
    for (int i = 0; i < 12 && i < seq.size(); i++) chk("t1_fun_seq", seq[i], exp_fun[i]);
    chk("t1_last_srcA", srcA, 32'h0000_FF00);

    // Fault injection on every vector.
    fault_inj = 1'b1;
    run_and_wait();
    chk("t2_fail_count", fail_count, 4'd12);
    chk("t2_first_fail", first_fail_idx, 4'd0);
    chk("t2_pass", pass, 1'b0);
    fault_inj = 1'b0;

    // ALU with broken arithmetic shift right.
    sra_bug = 1'b1;
    run_and_wait();
    chk("t3_fail_count", fail_count, 4'd1);
    chk("t3_first_fail", first_fail_idx, 4'd8);
    chk("t3_pass", pass, 1'b0);
    sra_bug = 1'b0;

    // Reset during CHECK of vector 5, then a clean run.
    fault_inj = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = m_busy && (m_c == 5 * P + 2);
    end
    #1;
    chk("t4_reached_check5", seen, 1'b1);
    chk("t4_pre_fail_count", fail_count, 4'd5);
    rst_n = 1'b0;
    #1;
    chk("t4_rst_busy", busy, 1'b0);
    chk("t4_rst_fail_count", fail_count, 4'd0);
    chk("t4_rst_first_fail", first_fail_idx, 4'hF);
    chk("t4_rst_alu_fun", alu_fun, 4'd0);
    chk("t4_rst_srcA", srcA, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    fault_inj = 1'b0;
    run_and_wait();
    chk("t4_busy_cycles", busy_cnt, 36);
    chk("t4_pass", pass, 1'b1);

    // start pulses while busy, then held through DONE.
    @(posedge clk); #1 start = 1'b1; busy_cnt = 0;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (8) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 start = 1'b1;
    wait_done();
    chk("t5_busy_cycles", busy_cnt, 36);
    @(negedge clk);
    chk("t5_restart_busy", busy, 1'b1);
    chk("t5_restart_done", done, 1'b0);
    @(posedge clk); #1 start = 1'b0;
    wait_done();
    chk("t5_pass", pass, 1'b1);

    // Short configuration: 3 vectors, no settle cycles.
    @(posedge clk); #1 start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = done2;
      if (busy2) n++;
    end
    chk("t6_done", seen, 1'b1);
    chk("t6_busy_cycles", n, 6);
    chk("t6_pass", pass2, 1'b1);
    chk("t6_fail_count", fc2, 4'd0);
    chk("t6_first_fail", ff2, 4'hF);
    chk("t6_last_fun", fun2, 4'd8);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
